// File: rtl/dsa_pixel_fetch_vec_if.sv
// dsa_pixel_fetch_vec_if
// Request, image-memory and neighbour-output bundle of the pixel fetcher.
interface dsa_pixel_fetch_vec_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int SIMD_WIDTH = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [15:0]             base_x;
  logic [15:0]             base_y;
  logic [15:0]             inv_scale_x;
  logic [15:0]             inv_scale_y;
  logic [ADDR_WIDTH-1:0]   img_base_addr;
  logic                    mem_read_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [7:0]              mem_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [8*SIMD_WIDTH-1:0] p00;
  logic [8*SIMD_WIDTH-1:0] p01;
  logic [8*SIMD_WIDTH-1:0] p10;
  logic [8*SIMD_WIDTH-1:0] p11;
  logic [8*SIMD_WIDTH-1:0] a;
  logic [8*SIMD_WIDTH-1:0] b;
  logic [SIMD_WIDTH-1:0]   clamped;
  logic                    busy;

  modport slave (
    input  req_valid, base_x, base_y,
    input  inv_scale_x, inv_scale_y,
    input  img_base_addr, mem_data, out_ready,
    output req_ready, mem_read_en, mem_addr,
    output out_valid, p00, p01, p10, p11,
    output a, b, clamped, busy
  );

  modport master (
    output req_valid, base_x, base_y,
    output inv_scale_x, inv_scale_y,
    output img_base_addr, mem_data, out_ready,
    input  req_ready, mem_read_en, mem_addr,
    input  out_valid, p00, p01, p10, p11,
    input  a, b, clamped, busy
  );
endinterface

// File: rtl/dsa_pixel_fetch_vec.sv
// dsa_pixel_fetch_vec
// Vector bilinear neighbour fetcher: coord calc, clamped reads, hold.
module dsa_pixel_fetch_vec #(
  parameter int ADDR_WIDTH  = 18,
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int SIMD_WIDTH  = 4,
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic rst_n,
  dsa_pixel_fetch_vec_if.slave bus
);
  localparam int S  = SIMD_WIDTH;
  localparam int L  = MEM_LATENCY;
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LW = (S > 1) ? $clog2(S) : 1;
  localparam int RW = $clog2(4 * S + 1);
  localparam logic [24:0] XMAX = 25'(IMG_WIDTH - 1);
  localparam logic [24:0] YMAX = 25'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE, CALC, FETCH, DRAIN, HOLD
  } state_t;

  state_t state_q, state_d;

  logic [15:0]           bx_q, by_q, sx_q, sy_q;
  logic [ADDR_WIDTH-1:0] ib_q;
  logic [LW-1:0]         cl_q;
  logic [RW-1:0]         rd_q;
  logic [XW-1:0]         x0_q [S];
  logic [XW-1:0]         x1_q [S];
  logic [YW-1:0]         y0_q, y1_q;
  logic [7:0]            la_q [S];
  logic [7:0]            lb_q;
  logic [S-1:0]          lc_q;

  logic                  re_q;
  logic [ADDR_WIDTH-1:0] ad_q;
  logic [LW-1:0]         tl_q;
  logic [1:0]            tn_q;
  logic [L-1:0]          pv_q;
  logic [LW-1:0]         pl_q [L];
  logic [1:0]            pn_q [L];

  logic [8*S-1:0] p00_q, p01_q, p10_q, p11_q;
  logic [8*S-1:0] a_q, b_q;
  logic [S-1:0]   c_q;

  logic [16:0] ex;
  logic [32:0] px, py;
  logic [24:0] ix, iy;
  logic [XW-1:0] cx0, cx1;
  logic [YW-1:0] cy0, cy1;
  logic cc;

  logic [LW-1:0] rl;
  logic [1:0] rn;
  logic fwd;
  logic [XW-1:0] ax;
  logic [YW-1:0] ay;
  logic [ADDR_WIDTH-1:0] addr_d;

  logic ret_v, ret_last;
  logic [LW-1:0] ret_l;
  logic [1:0] ret_n;
  logic idle, hold;

  // Current lane source coordinate, fraction and border clamp.
  always_comb begin
    ex  = {1'b0, bx_q} + 17'(cl_q);
    px  = 33'(ex) * 33'(sx_q);
    py  = 33'(by_q) * 33'(sy_q);
    ix  = px[32:8];
    iy  = py[32:8];
    cx0 = (ix >= XMAX) ? XW'(XMAX) : XW'(ix);
    cx1 = (ix >= XMAX) ? XW'(XMAX) : XW'(ix + 25'd1);
    cy0 = (iy >= YMAX) ? YW'(YMAX) : YW'(iy);
    cy1 = (iy >= YMAX) ? YW'(YMAX) : YW'(iy + 25'd1);
    cc  = (ix >= XMAX) || (iy >= YMAX);
  end

  // Address of the next read; lane 0 is forwarded when S is 1.
  always_comb begin
    rl     = LW'(rd_q >> 2);
    rn     = rd_q[1:0];
    fwd    = (state_q == CALC) && (cl_q == '0);
    ax     = rn[0] ? (fwd ? cx1 : x1_q[rl])
                   : (fwd ? cx0 : x0_q[rl]);
    ay     = rn[1] ? (fwd ? cy1 : y1_q)
                   : (fwd ? cy0 : y0_q);
    addr_d = ib_q + ADDR_WIDTH'(32'(ay) * IMG_WIDTH)
                  + ADDR_WIDTH'(ax);
  end

  // Tag of the byte returning this cycle.
  always_comb begin
    ret_v    = pv_q[L-1];
    ret_l    = pl_q[L-1];
    ret_n    = pn_q[L-1];
    ret_last = ret_v && (ret_l == LW'(S - 1))
                     && (ret_n == 2'd3);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.req_valid) state_d = CALC;
      CALC:  if (cl_q == LW'(S - 1)) state_d = FETCH;
      FETCH: if (rd_q == RW'(4 * S)) state_d = DRAIN;
      DRAIN: if (ret_last) state_d = HOLD;
      HOLD:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    idle = (state_q == IDLE);
    hold = (state_q == HOLD);
  end

  // Request latch and per-lane coordinate table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx_q <= '0;
      by_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      ib_q <= '0;
      cl_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
      lb_q <= '0;
      lc_q <= '0;
      for (int i = 0; i < S; i++) begin
        x0_q[i] <= '0;
        x1_q[i] <= '0;
        la_q[i] <= '0;
      end
    end else if (idle) begin
      cl_q <= '0;
      if (bus.req_valid) begin
        bx_q <= bus.base_x;
        by_q <= bus.base_y;
        sx_q <= bus.inv_scale_x;
        sy_q <= bus.inv_scale_y;
        ib_q <= bus.img_base_addr;
      end
    end else if (state_q == CALC) begin
      x0_q[cl_q] <= cx0;
      x1_q[cl_q] <= cx1;
      la_q[cl_q] <= px[7:0];
      lc_q[cl_q] <= cc;
      y0_q <= cy0;
      y1_q <= cy1;
      lb_q <= py[7:0];
      cl_q <= cl_q + LW'(1);
    end
  end

  // Read issue and return-tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= 1'b0;
      ad_q <= '0;
      tl_q <= '0;
      tn_q <= '0;
      rd_q <= '0;
      pv_q <= '0;
      for (int k = 0; k < L; k++) begin
        pl_q[k] <= '0;
        pn_q[k] <= '0;
      end
    end else begin
      re_q <= (state_d == FETCH);
      if (idle) begin
        rd_q <= '0;
      end else if (state_d == FETCH) begin
        ad_q <= addr_d;
        tl_q <= rl;
        tn_q <= rn;
        rd_q <= rd_q + RW'(1);
      end
      pv_q[0] <= re_q;
      pl_q[0] <= tl_q;
      pn_q[0] <= tn_q;
      for (int k = 1; k < L; k++) begin
        pv_q[k] <= pv_q[k-1];
        pl_q[k] <= pl_q[k-1];
        pn_q[k] <= pn_q[k-1];
      end
    end
  end

  // Output capture: bytes on return, weights with the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p00_q <= '0;
      p01_q <= '0;
      p10_q <= '0;
      p11_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
    end else begin
      if (ret_v) begin
        unique case (1'b1)
          ret_n == 2'd0: p00_q[8*int'(ret_l) +: 8] <= bus.mem_data;
          ret_n == 2'd1: p01_q[8*int'(ret_l) +: 8] <= bus.mem_data;
          ret_n == 2'd2: p10_q[8*int'(ret_l) +: 8] <= bus.mem_data;
          ret_n == 2'd3: p11_q[8*int'(ret_l) +: 8] <= bus.mem_data;
        endcase
      end
      if (state_q == DRAIN && ret_last) begin
        for (int i = 0; i < S; i++) begin
          a_q[8*i +: 8] <= la_q[i];
          b_q[8*i +: 8] <= lb_q;
        end
        c_q <= lc_q;
      end
    end
  end

  assign bus.req_ready   = idle;
  assign bus.busy        = !idle;
  assign bus.out_valid   = hold;
  assign bus.mem_read_en = re_q;
  assign bus.mem_addr    = ad_q;
  assign bus.p00         = p00_q;
  assign bus.p01         = p01_q;
  assign bus.p10         = p10_q;
  assign bus.p11         = p11_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.clamped     = c_q;
endmodule

// File: tb/tb_dsa_pixel_fetch_vec.sv
// tb_dsa_pixel_fetch_vec
// Directed vectors for the pixel fetcher, default and wide/slow instances.
module tb_dsa_pixel_fetch_vec;
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsa_pixel_fetch_vec_if #(.ADDR_WIDTH(18), .SIMD_WIDTH(4)) r0 ();
  dsa_pixel_fetch_vec_if #(.ADDR_WIDTH(18), .SIMD_WIDTH(8)) r1 ();

  dsa_pixel_fetch_vec #(
    .ADDR_WIDTH(18), .IMG_WIDTH(512), .IMG_HEIGHT(512),
    .SIMD_WIDTH(4), .MEM_LATENCY(1)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(r0));

  dsa_pixel_fetch_vec #(
    .ADDR_WIDTH(18), .IMG_WIDTH(512), .IMG_HEIGHT(512),
    .SIMD_WIDTH(8), .MEM_LATENCY(3)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(r1));

  // Memory byte mixes the row bits in so rows stay distinguishable.
  function automatic logic [7:0] mem_fn(input logic [17:0] ad);
    return ad[7:0] ^ ad[16:9];
  endfunction

  function automatic logic [17:0] adr(input int ib, input int x, input int y);
    return 18'(ib + y * 512 + x);
  endfunction

  logic [7:0] m0_q;
  logic [7:0] m1_q [3];
  always @(posedge clk) m0_q <= mem_fn(r0.mem_addr);
  always @(posedge clk) begin
    m1_q[0] <= mem_fn(r1.mem_addr);
    m1_q[1] <= m1_q[0];
    m1_q[2] <= m1_q[1];
  end
  assign r0.mem_data = m0_q;
  assign r1.mem_data = m1_q[2];

  // Vectors: identity, 2x, border, zero scale, fractional.
  int vbx [5] = '{10, 3, 510, 100, 2};
  int vby [5] = '{20, 4, 511, 200, 3};
  int vsx [5] = '{256, 128, 256, 0, 384};
  int vsy [5] = '{256, 128, 256, 0, 320};
  int vib [5] = '{0, 0, 0, 'h3FFF0, 'h155};
  int fx0 [5][4] = '{'{10, 11, 12, 13}, '{1, 2, 2, 3},
                     '{510, 511, 511, 511}, '{0, 0, 0, 0},
                     '{3, 4, 6, 7}};
  int fx1 [5][4] = '{'{11, 12, 13, 14}, '{2, 3, 3, 4},
                     '{511, 511, 511, 511}, '{1, 1, 1, 1},
                     '{4, 5, 7, 8}};
  int fy0 [5] = '{20, 2, 511, 0, 3};
  int fy1 [5] = '{21, 3, 511, 1, 4};
  int fa [5][4] = '{'{0, 0, 0, 0}, '{128, 0, 128, 0},
                    '{0, 0, 0, 0}, '{0, 0, 0, 0},
                    '{0, 128, 0, 128}};
  int fb [5] = '{0, 0, 0, 0, 192};
  int fc [5] = '{0, 0, 15, 0, 0};

  logic [63:0] e00, e01, e10, e11, ea, eb;
  logic [7:0]  ec;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mk_exp(input int k);
    e00 = '0; e01 = '0; e10 = '0; e11 = '0; ea = '0; eb = '0;
    for (int i = 0; i < 4; i++) begin
      e00[8*i +: 8] = mem_fn(adr(vib[k], fx0[k][i], fy0[k]));
      e01[8*i +: 8] = mem_fn(adr(vib[k], fx1[k][i], fy0[k]));
      e10[8*i +: 8] = mem_fn(adr(vib[k], fx0[k][i], fy1[k]));
      e11[8*i +: 8] = mem_fn(adr(vib[k], fx1[k][i], fy1[k]));
      ea[8*i +: 8]  = 8'(fa[k][i]);
      eb[8*i +: 8]  = 8'(fb[k]);
    end
    ec = 8'(fc[k]);
  endtask

  task automatic start0(input int k);
    r0.base_x        = 16'(vbx[k]);
    r0.base_y        = 16'(vby[k]);
    r0.inv_scale_x   = 16'(vsx[k]);
    r0.inv_scale_y   = 16'(vsy[k]);
    r0.img_base_addr = 18'(vib[k]);
    r0.req_valid     = 1'b1;
  endtask

  // Called at the negedge of cycle 1; returns at the out_valid negedge.
  task automatic wait0(input int t0, input int k);
    int nrd, fst, lst, ov, c;
    nrd = 0; fst = -1; lst = -1; ov = -1;
    for (int n = 0; n < 200 && ov < 0; n++) begin
      c = cyc - t0;
      if (r0.mem_read_en) begin
        nrd++;
        if (fst < 0) fst = c;
        lst = c;
      end
      if (r0.out_valid) ov = c;
      else @(negedge clk);
    end
    mk_exp(k);
    chk($sformatf("v%0d_nrd", k), nrd, 16);
    chk($sformatf("v%0d_rd_first", k), fst, 5);
    chk($sformatf("v%0d_rd_last", k), lst, 20);
    chk($sformatf("v%0d_ov_cyc", k), ov, 22);
    chk($sformatf("v%0d_p00", k), r0.p00, e00);
    chk($sformatf("v%0d_p01", k), r0.p01, e01);
    chk($sformatf("v%0d_p10", k), r0.p10, e10);
    chk($sformatf("v%0d_p11", k), r0.p11, e11);
    chk($sformatf("v%0d_a", k), r0.a, ea);
    chk($sformatf("v%0d_b", k), r0.b, eb);
    chk($sformatf("v%0d_clamped", k), r0.clamped, ec);
  endtask

  int t0, stable;
  int nrd1, fst1, lst1, ov1, c1;
  logic [63:0] w00, w01, w10, w11;

  initial begin
    rst_n = 1'b0;
    r0.req_valid = 1'b0; r0.out_ready = 1'b1;
    r0.base_x = '0; r0.base_y = '0;
    r0.inv_scale_x = '0; r0.inv_scale_y = '0;
    r0.img_base_addr = '0;
    r1.req_valid = 1'b0; r1.out_ready = 1'b1;
    r1.base_x = '0; r1.base_y = '0;
    r1.inv_scale_x = '0; r1.inv_scale_y = '0;
    r1.img_base_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", r0.req_ready, 1);
    chk("rst_out_valid", r0.out_valid, 0);
    chk("rst_read_en", r0.mem_read_en, 0);
    chk("rst_busy", r0.busy, 0);
    chk("rst_p00", r0.p00, 0);
    chk("rst_clamped", r0.clamped, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start0(k);
      t0 = cyc;
      chk($sformatf("v%0d_req_ready", k), r0.req_ready, 1);
      @(negedge clk);
      r0.req_valid = 1'b0;
      wait0(t0, k);
      @(negedge clk);
      chk($sformatf("v%0d_ov_drop", k), r0.out_valid, 0);
      chk($sformatf("v%0d_idle", k), r0.req_ready, 1);
    end

    // Backpressure with a second request pending throughout HOLD.
    @(negedge clk);
    start0(4);
    t0 = cyc;
    r0.out_ready = 1'b0;
    @(negedge clk);
    start0(1);
    wait0(t0, 4);
    stable = 0;
    repeat (10) begin
      if (r0.out_valid && !r0.req_ready && r0.p00 == e00[31:0]
          && r0.p11 == e11[31:0] && r0.b == eb[31:0])
        stable++;
      @(negedge clk);
    end
    chk("bp_stable", stable, 10);
    r0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ov_drop", r0.out_valid, 0);
    chk("bp_req_ready", r0.req_ready, 1);
    t0 = cyc;
    @(negedge clk);
    chk("bp_accepted", r0.busy, 1);
    r0.req_valid = 1'b0;
    wait0(t0, 1);
    @(negedge clk);

    // Reset in the middle of FETCH.
    @(negedge clk);
    start0(0);
    t0 = cyc;
    @(negedge clk);
    r0.req_valid = 1'b0;
    while (cyc - t0 < 10) @(negedge clk);
    chk("mid_read_en", r0.mem_read_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read_en", r0.mem_read_en, 0);
    chk("mid_rst_busy", r0.busy, 0);
    chk("mid_rst_out_valid", r0.out_valid, 0);
    chk("mid_rst_p00", r0.p00, 0);
    chk("mid_rst_req_ready", r0.req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start0(4);
    t0 = cyc;
    @(negedge clk);
    r0.req_valid = 1'b0;
    wait0(t0, 4);
    @(negedge clk);

    // Eight lanes, three-cycle memory, identity mapping.
    @(negedge clk);
    r1.base_x = 16'd10; r1.base_y = 16'd20;
    r1.inv_scale_x = 16'd256; r1.inv_scale_y = 16'd256;
    r1.img_base_addr = '0;
    r1.req_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    r1.req_valid = 1'b0;
    nrd1 = 0; fst1 = -1; lst1 = -1; ov1 = -1;
    for (int n = 0; n < 300 && ov1 < 0; n++) begin
      c1 = cyc - t0;
      if (r1.mem_read_en) begin
        nrd1++;
        if (fst1 < 0) fst1 = c1;
        lst1 = c1;
      end
      if (r1.out_valid) ov1 = c1;
      else @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      w00[8*i +: 8] = mem_fn(adr(0, 10 + i, 20));
      w01[8*i +: 8] = mem_fn(adr(0, 11 + i, 20));
      w10[8*i +: 8] = mem_fn(adr(0, 10 + i, 21));
      w11[8*i +: 8] = mem_fn(adr(0, 11 + i, 21));
    end
    chk("w_nrd", nrd1, 32);
    chk("w_rd_first", fst1, 9);
    chk("w_rd_last", lst1, 40);
    chk("w_ov_cyc", ov1, 44);
    chk("w_p00", r1.p00, w00);
    chk("w_p01", r1.p01, w01);
    chk("w_p10", r1.p10, w10);
    chk("w_p11", r1.p11, w11);
    chk("w_a", r1.a, 0);
    chk("w_b", r1.b, 0);
    chk("w_clamped", r1.clamped, 0);
    @(negedge clk);
    chk("w_ov_drop", r1.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dsa_pixel_fetch_vec.md
# dsa_pixel_fetch_vec

Parametrised vector pixel-fetch engine for the bilinear scaler datapath. For each accepted request it maps `SIMD_WIDTH` consecutive destination pixels to source coordinates using independent X/Y inverse scales. It fetches the four neighbours of every lane from single-port image memory with a configurable fixed read latency, clamping coordinates at the image borders. It presents the neighbour bytes and fractional weights to the interpolation lanes through a valid/ready handshake.

## Interface
- `ADDR_WIDTH`, 18, memory address width.
- `IMG_WIDTH`, 512, source image width in pixels.
- `IMG_HEIGHT`, 512, source image height in pixels.
- `SIMD_WIDTH`, 4, lanes per request; legal range 1..16.
- `MEM_LATENCY`, 1, cycles from read issue to data valid; legal range 1..4.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active low.
- `req_valid` in 1: request valid.
- `req_ready` out 1: high only in IDLE.
- `base_x`, `base_y` in 16: destination coordinate of lane 0.
- `inv_scale_x`, `inv_scale_y` in 16: unsigned Q8.8 inverse scale; 256 = 1.0.
- `img_base_addr` in ADDR_WIDTH: address of source pixel (0,0).
- `mem_read_en` out 1: registered read strobe.
- `mem_addr` out ADDR_WIDTH: registered read address.
- `mem_data` in 8: read data, valid `MEM_LATENCY` cycles after issue.
- `out_valid` out 1: neighbour set valid.
- `out_ready` in 1: consumer accepts the set.
- `p00`, `p01`, `p10`, `p11` out 8 x SIMD_WIDTH: neighbours (x0,y0), (x1,y0), (x0,y1), (x1,y1).
- `a`, `b` out 8 x SIMD_WIDTH: X and Y fractions in Q0.8.
- `clamped` out SIMD_WIDTH: lane touched a border.
- `busy` out 1: state is not IDLE.

## Operation
- **Request capture:** a handshake (`req_valid && req_ready`) latches `base_*`, `inv_scale_*` and `img_base_addr`. `req_valid` is ignored outside IDLE.
- **FSM:** IDLE → CALC → FETCH → DRAIN → HOLD → IDLE.
  - CALC runs one lane per cycle for `SIMD_WIDTH` cycles.
  - FETCH issues reads back-to-back for 4·SIMD_WIDTH cycles.
  - DRAIN waits for the last return.
  - HOLD asserts `out_valid` until `out_ready`.
- **Lane i coordinate math:**
  - prod_x = (base_x + i) [17b] × inv_scale_x = 33b.
  - int_x = prod_x[32:8]; a[i] = prod_x[7:0]. Y is identical using base_y and inv_scale_y.
- **Clamping:**
  - x0 = min(int_x, IMG_WIDTH-1); x1 = min(int_x+1, IMG_WIDTH-1). y0/y1 are clamped the same way against IMG_HEIGHT-1.
  - `clamped[i]` = (int_x ≥ IMG_WIDTH-1) || (int_y ≥ IMG_HEIGHT-1).
  - Fractions are never modified by clamping.
- **Addressing:** address = img_base_addr + y·IMG_WIDTH + x, truncated modulo 2^ADDR_WIDTH.
- **Read order:** lane-major (lane 0..S-1); within a lane the order is 00, 01, 10, 11. Read n targets lane n/4, neighbour n%4.
- **Return tracking:** a `MEM_LATENCY`-deep shift register carries {valid, lane, neighbour} and selects the capture target for each returning byte.
- **Output registers:** outputs change only on capture. They are stable throughout HOLD.
- **Zero scale:** an inverse scale of 0 is legal. Every lane maps to source pixel (0,0).

## Timing
- **Reset values:**
  - All outputs 0, except `req_ready` = 1.
  - State is IDLE and the return pipeline is cleared.
  - `mem_read_en` and `out_valid` drop immediately on `rst_n` low.
- **Cycle numbering:** cycle 0 is the request handshake. CALC occupies cycles 1..S (S = SIMD_WIDTH).
- **Reads:** `mem_read_en` is high on exactly cycles S+1..5S, with no gaps. Read n is issued in cycle S+1+n, and its data is captured at the end of cycle S+1+n+MEM_LATENCY.
- **Output valid:** `out_valid` rises in cycle 5S+MEM_LATENCY+1. With defaults this is cycle 22.
- **Output handshake:** transfer occurs when `out_valid && out_ready`. The FSM returns to IDLE the next cycle, and `req_ready` rises that cycle.
  - If `out_ready` is already high, `out_valid` lasts exactly one cycle.
- **Reset mid-operation:** the transaction is abandoned. Memory returns arriving after reset release are ignored.

## Test plan
- **Identity, defaults:** inv_scale 256/256, base (10,20), memory model returns addr[7:0], img_base 0.
  - Required: `mem_read_en` high for exactly 16 cycles (cycles 5..20).
  - Required: p00[i] = (20·512+10+i)&FF, p01[i] = p00[i]+1, p10[i] = (21·512+10+i)&FF.
  - Required: a = b = 0, `out_valid` at cycle 22, `clamped` = 0.
- **2x upscale:** inv_scale 128, base (3,4).
  - Required: lane int_x = 1, 2, 2, 3 and a = 128, 0, 128, 0; int_y = 2 and b = 0.
- **Border:** identity, base (510,511).
  - Required: lane0 x0/x1 = 510/511; lanes 1-3 x0 = x1 = 511; y0 = y1 = 511.
  - Required: `clamped` = 4'b1111 (y at the last row).
- **Latency instance:** MEM_LATENCY = 3, SIMD_WIDTH = 8, stimulus as the identity test.
  - Required: 32 contiguous reads, `out_valid` at cycle 44, all 8 lanes correct.
- **Backpressure:** hold `out_ready` low for 10 cycles with `req_valid` high.
  - Required: outputs stable and `req_ready` low. After the handshake, the next request is accepted one cycle later.
- **Reset mid-FETCH:** assert `rst_n` low at cycle 10.
  - Required: `mem_read_en` = 0 and `busy` = 0 immediately; outputs 0.
  - Required: a subsequent request completes with correct data.
